serial_read_ctrl: RTL and testbench

//  Read-side controller for the async FIFO in the clk_out domain. Pops one

---
 rtl/serial_read_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_read_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_read_ctrl.sv
// Read-side controller for an async FIFO: pops one word at a time, shifts it out
// MSB-first over a valid/ready bit interface, and sequences pointer flushes.
module serial_read_ctrl #(
   parameter int DATA_W    = 8,
   parameter int FLUSH_CYC = 4,
   parameter int CNT_W     = 16
) (
   input  logic              clk_out,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rdata,
   output logic              fifo_rd_en,
   input  logic              flush_req,
   output logic              sync_flush,
   output logic              flush_busy,
   input  logic              ser_ready,
   output logic              ser_valid,
   output logic              ser_out,
   output logic              ser_first,
   output logic [CNT_W-1:0]  words_sent
);

   localparam int BCW = $clog2(DATA_W);
   localparam int FCW = $clog2(FLUSH_CYC);
   localparam logic [BCW-1:0] BIT_TOP   = BCW'(DATA_W - 1);
   localparam logic [FCW-1:0] FLUSH_TOP = FCW'(FLUSH_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      SHIFT,
      FLUSH
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]  words_q, words_d;
   logic              flush_pend_q, flush_pend_d;
   logic [FCW-1:0]    flush_cnt_q, flush_cnt_d;

   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         words_q      <= '0;
         flush_pend_q <= 1'b0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         words_q      <= words_d;
         flush_pend_q <= flush_pend_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      words_d      = words_q;
      flush_cnt_d  = flush_cnt_q;
      // A request arriving outside FLUSH is remembered until the flush completes
      flush_pend_d = flush_pend_q | (flush_req && (state_q != FLUSH));
      fifo_rd_en   = 1'b0;
      sync_flush   = 1'b0;
      ser_valid    = 1'b0;
      ser_out      = 1'b0;
      ser_first    = 1'b0;

      case (state_q)
         IDLE: begin
            if (flush_pend_q || flush_req) begin
               state_d = FLUSH;
            end else if (!fifo_empty) begin
               state_d = POP;
            end
         end
         POP: begin
            fifo_rd_en = 1'b1;
            state_d    = LOAD;
         end
         LOAD: begin
            shreg_d   = fifo_rdata;
            bit_cnt_d = BIT_TOP;
            state_d   = SHIFT;
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = shreg_q[DATA_W-1];
            ser_first = (bit_cnt_q == BIT_TOP);
            if (ser_ready) begin
               if (bit_cnt_q != '0) begin
                  shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q - BCW'(1);
               end else begin
                  words_d = words_q + CNT_W'(1);
                  if (flush_pend_q || flush_req) begin
                     state_d = FLUSH;
                  end else if (!fifo_empty) begin
                     state_d = POP;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         FLUSH: begin
            sync_flush = 1'b1;
            if (flush_cnt_q == FLUSH_TOP) begin
               flush_cnt_d  = '0;
               flush_pend_d = 1'b0;
               state_d      = IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q + FCW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign flush_busy = flush_pend_q | (state_q == FLUSH);
   assign words_sent = words_q;

endmodule

// File: tb/tb_serial_read_ctrl.sv
// Scoreboard bench for serial_read_ctrl: a FIFO model feeds words, expected
// bits are queued at push time and a negedge monitor checks every handshake.
module tb_serial_read_ctrl;

   localparam int DATA_W    = 8;
   localparam int FLUSH_CYC = 4;
   localparam int CNT_W     = 16;

   logic              clk_out = 1'b0;
   logic              rst = 1'b1;
   logic              fifo_empty = 1'b1;
   logic [DATA_W-1:0] fifo_rdata = '0;
   logic              fifo_rd_en;
   logic              flush_req = 1'b0;
   logic              sync_flush;
   logic              flush_busy;
   logic              ser_ready = 1'b0;
   logic              ser_valid;
   logic              ser_out;
   logic              ser_first;
   logic [CNT_W-1:0]  words_sent;

   serial_read_ctrl #(
      .DATA_W   (DATA_W),
      .FLUSH_CYC(FLUSH_CYC),
      .CNT_W    (CNT_W)
   ) dut (
      .clk_out   (clk_out),
      .rst       (rst),
      .fifo_empty(fifo_empty),
      .fifo_rdata(fifo_rdata),
      .fifo_rd_en(fifo_rd_en),
      .flush_req (flush_req),
      .sync_flush(sync_flush),
      .flush_busy(flush_busy),
      .ser_ready (ser_ready),
      .ser_valid (ser_valid),
      .ser_out   (ser_out),
      .ser_first (ser_first),
      .words_sent(words_sent)
   );

   always #5 clk_out = ~clk_out;

   typedef struct packed {
      logic first;
      logic b;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] fifo_q[$];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int rd_en_cnt = 0;
   int hs_cnt = 0;
   int stall_cnt = 0;
   int last_hs_cyc = 0;
   int last_first_cyc = 0;
   int prev_first_cyc = 0;
   logic stall_q = 1'b0;
   logic stall_bit = 1'b0;
   logic stall_first = 1'b0;

   always @(posedge clk_out) cyc <= cyc + 1;

   // FIFO model: data appears in the cycle after the pop strobe
   always @(negedge clk_out) begin
      if (!rst && fifo_rd_en) begin
         rd_en_cnt++;
         vectors++;
         if (fifo_q.size() == 0) begin
            miscompares++;
            $display("FAIL pop_when_empty: got pop with 0 words queued, required no pop");
         end else begin
            fifo_rdata = fifo_q.pop_front();
         end
      end
      fifo_empty = (fifo_q.size() == 0);
   end

   // Monitor: compares each consumed bit and checks bits hold across stalls
   always @(negedge clk_out) begin
      exp_t e;
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            vectors++;
            if ({ser_valid, ser_out, ser_first} !== {1'b1, stall_bit, stall_first}) begin
               miscompares++;
               $display("FAIL stall_hold: got v/b/f=%b%b%b required 1%b%b",
                        ser_valid, ser_out, ser_first, stall_bit, stall_first);
            end
         end
         if (ser_valid && ser_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_bit: got bit=%b first=%b with no bit expected",
                        ser_out, ser_first);
            end else begin
               e = exp_q.pop_front();
               if ({ser_first, ser_out} !== {e.first, e.b}) begin
                  miscompares++;
                  $display("FAIL serial_bit: got bit=%b first=%b required bit=%b first=%b",
                           ser_out, ser_first, e.b, e.first);
               end
            end
            hs_cnt++;
            last_hs_cyc = cyc;
            if (ser_first) begin
               prev_first_cyc = last_first_cyc;
               last_first_cyc = cyc;
            end
         end
         if (ser_valid && !ser_ready) stall_cnt++;
         stall_q     = ser_valid && !ser_ready;
         stall_bit   = ser_out;
         stall_first = ser_first;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [DATA_W-1:0] w);
      exp_t e;
      fifo_q.push_back(w);
      for (int i = DATA_W - 1; i >= 0; i--) begin
         e.first = (i == DATA_W - 1);
         e.b     = w[i];
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int good = 0;
      for (int i = 0; i < 300 && good < 2; i++) begin
         @(negedge clk_out);
         if (exp_q.size() == 0 && fifo_q.size() == 0 && !ser_valid && !flush_busy &&
             !fifo_rd_en && !sync_flush)
            good++;
         else
            good = 0;
      end
      check("drain_done", good, 2);
   endtask

   task automatic wait_hs(input int target);
      int ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_out);
         if (hs_cnt >= target) begin
            ok = 1;
            break;
         end
      end
      check("wait_handshake", ok, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r0, h0, busy_low, sync_seen, sync_start, early, s0;
      logic [3:0] pat;

      // Reset state
      repeat (3) @(negedge clk_out);
      check("rst_rd_en", int'(fifo_rd_en), 0);
      check("rst_sync_flush", int'(sync_flush), 0);
      check("rst_flush_busy", int'(flush_busy), 0);
      check("rst_ser_valid", int'(ser_valid), 0);
      check("rst_ser_out_first", int'({ser_out, ser_first}), 0);
      check("rst_words_sent", int'(words_sent), 0);
      @(posedge clk_out); #1;
      rst = 1'b0;
      ser_ready = 1'b1;

      // 1: single word A5 at full rate
      @(posedge clk_out); #1;
      r0 = rd_en_cnt;
      push_word(8'hA5);
      wait_drain();
      check("t1_words_sent", int'(words_sent), 1);
      check("t1_rd_pulses", rd_en_cnt - r0, 1);
      check("t1_frame_span", last_hs_cyc - last_first_cyc, 7);

      // 2: back-to-back FF, 00
      @(posedge clk_out); #1;
      r0 = rd_en_cnt;
      push_word(8'hFF);
      push_word(8'h00);
      wait_drain();
      check("t2_words_sent", int'(words_sent), 3);
      check("t2_rd_pulses", rd_en_cnt - r0, 2);
      check("t2_first_to_first", last_first_cyc - prev_first_cyc, 10);
      check("t2_frame_span", last_hs_cyc - last_first_cyc, 7);

      // 3: stalls on 3C with ready pattern 1,0,0,1
      @(posedge clk_out); #1;
      s0 = stall_cnt;
      pat = 4'b1001;
      push_word(8'h3C);
      for (int k = 0; k < 200 && exp_q.size() > 0; k++) begin
         ser_ready = pat[3 - (k % 4)];
         @(posedge clk_out); #1;
      end
      ser_ready = 1'b1;
      wait_drain();
      check("t3_words_sent", int'(words_sent), 4);
      check("t3_stalls_seen", int'(stall_cnt > s0), 1);

      // 4: flush request mid-frame on C3
      @(posedge clk_out); #1;
      h0 = hs_cnt;
      push_word(8'hC3);
      wait_hs(h0 + 3);
      @(posedge clk_out); #1;
      flush_req = 1'b1;
      @(posedge clk_out); #1;
      flush_req = 1'b0;
      busy_low = 0;
      sync_seen = 0;
      sync_start = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk_out);
         if (sync_flush) begin
            if (sync_seen == 0) sync_start = cyc;
            sync_seen++;
         end else if (sync_seen > 0) begin
            break;
         end
         if (!flush_busy) busy_low++;
      end
      check("t4_busy_gaps", busy_low, 0);
      check("t4_sync_cycles", sync_seen, FLUSH_CYC);
      check("t4_sync_after_last_bit", sync_start, last_hs_cyc + 1);
      check("t4_bits_sent", hs_cnt - h0, 8);
      check("t4_busy_after", int'(flush_busy), 0);
      wait_drain();
      check("t4_words_sent", int'(words_sent), 5);

      // 5: flush and non-empty in the same IDLE cycle
      @(posedge clk_out); #1;
      r0 = rd_en_cnt;
      push_word(8'h5A);
      flush_req = 1'b1;
      @(posedge clk_out); #1;
      flush_req = 1'b0;
      early = 0;
      sync_seen = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk_out);
         if (fifo_rd_en) early++;
         if (sync_flush) sync_seen++;
         else if (sync_seen > 0) break;
      end
      check("t5_pop_during_flush", early, 0);
      check("t5_sync_cycles", sync_seen, FLUSH_CYC);
      wait_drain();
      check("t5_words_sent", int'(words_sent), 6);
      check("t5_rd_pulses", rd_en_cnt - r0, 1);

      // 6: asynchronous reset mid-frame, then restart
      @(posedge clk_out); #1;
      h0 = hs_cnt;
      push_word(8'h96);
      wait_hs(h0 + 4);
      @(posedge clk_out); #3;
      rst = 1'b1;
      #1;
      check("t6_ser_valid", int'(ser_valid), 0);
      check("t6_ser_out_first", int'({ser_out, ser_first}), 0);
      check("t6_words_sent", int'(words_sent), 0);
      check("t6_flags", int'({fifo_rd_en, sync_flush, flush_busy}), 0);
      exp_q.delete();
      repeat (2) @(posedge clk_out);
      #1;
      rst = 1'b0;
      r0 = rd_en_cnt;
      push_word(8'h69);
      wait_drain();
      check("t6_words_after", int'(words_sent), 1);
      check("t6_rd_pulses", rd_en_cnt - r0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
